// File: rtl/borrow_select_subtractor_seq_if.sv
// Operand/result bus for the sequential borrow-select subtractor.
// Valid/ready on both sides; the DUT uses the slave modport.
interface borrow_select_subtractor_seq_if #(
  parameter int unsigned WIDTH = 16
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             zero;
  logic             ovf;

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout, zero, ovf
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout, zero, ovf
  );
endinterface

// File: rtl/borrow_select_subtractor_seq.sv
// Multi-cycle a - b - bin, one SLICE-bit borrow-select slice per clock, LSB first.
// Optional signed overflow flag enabled by macro BSS_SIGNED_OVF_EN.
module borrow_select_subtractor_seq #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SLICE = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  borrow_select_subtractor_seq_if.slave bus
);

  localparam int unsigned N     = WIDTH / SLICE;
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned SH_W  = $clog2(WIDTH) + 1;
  localparam int unsigned MSB   = WIDTH - 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             r_state, w_state_nxt;
  logic [WIDTH-1:0]   r_a, w_a_nxt;
  logic [WIDTH-1:0]   r_b, w_b_nxt;
  logic               r_borrow, w_borrow_nxt;
  logic [IDX_W-1:0]   r_idx, w_idx_nxt;
  logic [WIDTH-1:0]   r_diff, w_diff_nxt;
  logic               r_bout, w_bout_nxt;
  logic               r_zero, w_zero_nxt;
  logic               r_ovf, w_ovf_nxt;
  logic               r_out_valid, w_out_valid_nxt;

  logic               w_in_ready;
  logic [SH_W-1:0]    w_sh;
  logic [WIDTH-1:0]   w_a_sh, w_b_sh;
  logic [SLICE-1:0]   w_a_k, w_b_k;
  logic [SLICE:0]     w_d0, w_d1, w_sel;
  logic [WIDTH-1:0]   w_mask, w_ins, w_diff_upd;
  logic               w_last;

  assign w_in_ready    = (r_state == IDLE) && !rst;
  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.diff      = r_diff;
  assign bus.bout      = r_bout;
  assign bus.zero      = r_zero;
  assign bus.ovf       = r_ovf;

  // Current slice of both operands, with both borrow-in outcomes precomputed
  assign w_sh   = SH_W'(r_idx) * SH_W'(SLICE);
  assign w_a_sh = r_a >> w_sh;
  assign w_b_sh = r_b >> w_sh;
  assign w_a_k  = w_a_sh[SLICE-1:0];
  assign w_b_k  = w_b_sh[SLICE-1:0];
  assign w_d0   = {1'b0, w_a_k} - {1'b0, w_b_k};
  assign w_d1   = {1'b0, w_a_k} - {1'b0, w_b_k} - (SLICE+1)'(1);
  assign w_sel  = r_borrow ? w_d1 : w_d0;

  assign w_mask     = WIDTH'({SLICE{1'b1}}) << w_sh;
  assign w_ins      = WIDTH'(w_sel[SLICE-1:0]) << w_sh;
  assign w_diff_upd = (r_diff & ~w_mask) | w_ins;
  assign w_last     = (r_idx == IDX_W'(N - 1));

  // Next-state and datapath updates
  always_comb begin
    w_state_nxt     = r_state;
    w_a_nxt         = r_a;
    w_b_nxt         = r_b;
    w_borrow_nxt    = r_borrow;
    w_idx_nxt       = r_idx;
    w_diff_nxt      = r_diff;
    w_bout_nxt      = r_bout;
    w_zero_nxt      = r_zero;
    w_out_valid_nxt = r_out_valid;
`ifdef BSS_SIGNED_OVF_EN
    w_ovf_nxt       = r_ovf;
`else
    w_ovf_nxt       = 1'b0;
`endif

    unique case (r_state)
      IDLE: begin
        if (bus.in_valid && w_in_ready) begin
          w_a_nxt      = bus.a;
          w_b_nxt      = bus.b;
          w_borrow_nxt = bus.bin;
          w_idx_nxt    = '0;
          w_state_nxt  = BUSY;
        end
      end
      BUSY: begin
        w_diff_nxt   = w_diff_upd;
        w_borrow_nxt = w_sel[SLICE];
        w_idx_nxt    = r_idx + IDX_W'(1);
        if (w_last) begin
          w_idx_nxt       = '0;
          w_bout_nxt      = w_sel[SLICE];
          w_zero_nxt      = (w_diff_upd == '0);
`ifdef BSS_SIGNED_OVF_EN
          w_ovf_nxt       = (r_a[MSB] != r_b[MSB]) && (w_diff_upd[MSB] != r_a[MSB]);
`endif
          w_out_valid_nxt = 1'b1;
          w_state_nxt     = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          w_out_valid_nxt = 1'b0;
          w_state_nxt     = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_borrow    <= 1'b0;
      r_idx       <= '0;
      r_diff      <= '0;
      r_bout      <= 1'b0;
      r_zero      <= 1'b0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_a         <= w_a_nxt;
      r_b         <= w_b_nxt;
      r_borrow    <= w_borrow_nxt;
      r_idx       <= w_idx_nxt;
      r_diff      <= w_diff_nxt;
      r_bout      <= w_bout_nxt;
      r_zero      <= w_zero_nxt;
      r_ovf       <= w_ovf_nxt;
      r_out_valid <= w_out_valid_nxt;
    end
  end

endmodule

// File: tb/tb_borrow_select_subtractor_seq.sv
// Directed bench for borrow_select_subtractor_seq (WIDTH=16, SLICE=4).
// Expected values are hand-computed constants.
module tb_borrow_select_subtractor_seq;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned SLICE = 4;
  localparam int unsigned LAT   = WIDTH / SLICE;

`ifdef BSS_SIGNED_OVF_EN
  localparam logic OVF_8000 = 1'b1;
`else
  localparam logic OVF_8000 = 1'b0;
`endif

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  borrow_select_subtractor_seq_if #(.WIDTH(WIDTH)) u_if ();

  borrow_select_subtractor_seq #(.WIDTH(WIDTH), .SLICE(SLICE)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands, wait for out_valid and check latency / in_ready during the op
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic bin);
    int   lat;
    logic rdy_leak;
    chk({tag, "_in_ready_idle"}, 32'(u_if.in_ready), 32'd1);
    u_if.in_valid = 1'b1;
    u_if.a        = a;
    u_if.b        = b;
    u_if.bin      = bin;
    tick();
    u_if.in_valid = 1'b0;
    lat      = 0;
    rdy_leak = 1'b0;
    while (!u_if.out_valid && lat < 20) begin
      if (u_if.in_ready) rdy_leak = 1'b1;
      tick();
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'(LAT));
    chk({tag, "_in_ready_busy"}, 32'(rdy_leak | u_if.in_ready), 32'd0);
  endtask

  task automatic check_res(input string tag, input logic [15:0] diff, input logic bout,
                           input logic zero);
    chk({tag, "_diff"}, 32'(u_if.diff), 32'(diff));
    chk({tag, "_bout"}, 32'(u_if.bout), 32'(bout));
    chk({tag, "_zero"}, 32'(u_if.zero), 32'(zero));
  endtask

  task automatic handshake(input string tag);
    u_if.out_ready = 1'b1;
    tick();
    u_if.out_ready = 1'b0;
    chk({tag, "_out_valid_clr"}, 32'(u_if.out_valid), 32'd0);
    chk({tag, "_in_ready_after"}, 32'(u_if.in_ready), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks       = 0;
    n_fail         = 0;
    rst            = 1'b1;
    u_if.in_valid  = 1'b0;
    u_if.a         = '0;
    u_if.b         = '0;
    u_if.bin       = 1'b0;
    u_if.out_ready = 1'b0;
    tick();
    tick();
    chk("rst_in_ready_during", 32'(u_if.in_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_out_valid", 32'(u_if.out_valid), 32'd0);
    chk("rst_diff", 32'(u_if.diff), 32'd0);
    chk("rst_bout", 32'(u_if.bout), 32'd0);
    chk("rst_zero", 32'(u_if.zero), 32'd0);
    chk("rst_ovf", 32'(u_if.ovf), 32'd0);
    chk("rst_in_ready", 32'(u_if.in_ready), 32'd1);

    run_op("basic", 16'h1234, 16'h0234, 1'b0);
    check_res("basic", 16'h1000, 1'b0, 1'b0);
    handshake("basic");

    run_op("uflow", 16'h0000, 16'h0001, 1'b0);
    check_res("uflow", 16'hFFFF, 1'b1, 1'b0);
    handshake("uflow");

    run_op("eq_bin", 16'h0005, 16'h0005, 1'b1);
    check_res("eq_bin", 16'hFFFF, 1'b1, 1'b0);
    handshake("eq_bin");

    run_op("zero_bin", 16'h0000, 16'h0000, 1'b1);
    check_res("zero_bin", 16'hFFFF, 1'b1, 1'b0);
    handshake("zero_bin");

    run_op("zflag", 16'hABCD, 16'hABCD, 1'b0);
    check_res("zflag", 16'h0000, 1'b0, 1'b1);
    handshake("zflag");

    // Backpressure: result held, competing operands ignored
    run_op("bp", 16'h0010, 16'h0003, 1'b0);
    u_if.in_valid = 1'b1;
    u_if.a        = 16'h0003;
    u_if.b        = 16'h0001;
    u_if.bin      = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_valid", 32'(u_if.out_valid), 32'd1);
      chk("bp_hold_diff", 32'(u_if.diff), 32'h000D);
      chk("bp_hold_in_ready", 32'(u_if.in_ready), 32'd0);
    end
    handshake("bp");
    chk("bp_diff_kept", 32'(u_if.diff), 32'h000D);
    u_if.in_valid = 1'b0;
    run_op("bp_new", 16'h0003, 16'h0001, 1'b0);
    check_res("bp_new", 16'h0002, 1'b0, 1'b0);
    handshake("bp_new");

    // Reset two cycles into an operation
    u_if.in_valid = 1'b1;
    u_if.a        = 16'hFFFF;
    u_if.b        = 16'h0001;
    u_if.bin      = 1'b0;
    tick();
    u_if.in_valid = 1'b0;
    tick();
    tick();
    chk("mid_partial_diff", 32'(u_if.diff), 32'h00FE);
    rst = 1'b1;
    tick();
    chk("mid_out_valid", 32'(u_if.out_valid), 32'd0);
    chk("mid_diff", 32'(u_if.diff), 32'd0);
    chk("mid_bout", 32'(u_if.bout), 32'd0);
    rst = 1'b0;
    #1;
    chk("mid_in_ready", 32'(u_if.in_ready), 32'd1);
    tick();
    chk("mid_idle_out_valid", 32'(u_if.out_valid), 32'd0);
    run_op("post_rst", 16'h0010, 16'h0008, 1'b0);
    check_res("post_rst", 16'h0008, 1'b0, 1'b0);
    handshake("post_rst");

    run_op("ovf_pos", 16'h8000, 16'h0001, 1'b0);
    check_res("ovf_pos", 16'h7FFF, 1'b0, 1'b0);
    chk("ovf_pos_ovf", 32'(u_if.ovf), 32'(OVF_8000));
    handshake("ovf_pos");

    run_op("ovf_neg", 16'h7FFF, 16'h0001, 1'b0);
    check_res("ovf_neg", 16'h7FFE, 1'b0, 1'b0);
    chk("ovf_neg_ovf", 32'(u_if.ovf), 32'd0);
    handshake("ovf_neg");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
